// File: rtl/roundrobin_arbiter_lock.sv
// N-way round-robin arbiter whose grant stays locked until the owner releases it.
// Optional forced release after HOLD_LIMIT cycles: define ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN.
module roundrobin_arbiter_lock #(
    parameter int REQUESTERS = 4,
    parameter int HOLD_LIMIT = 16,
    localparam int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [REQUESTERS-1:0]  i_request,
    input  logic [REQUESTERS-1:0]  i_free,
    output logic [REQUESTERS-1:0]  o_grant,
    output logic                   o_grant_valid,
    output logic [INDEX_WIDTH-1:0] o_grant_index,
    output logic                   o_timeout
);

    typedef enum logic [0:0] {
        S_IDLE,
        S_LOCKED
    } state_t;

    if (REQUESTERS < 2 || REQUESTERS > 32 ||
        HOLD_LIMIT < 2 || HOLD_LIMIT > 65535) begin : g_param_check
        $error("roundrobin_arbiter_lock: parameter out of range");
    end

    state_t                 r_state;
    state_t                 w_state;
    logic [REQUESTERS-1:0]  r_grant;
    logic [REQUESTERS-1:0]  w_grant;
    logic                   r_valid;
    logic                   w_valid;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [INDEX_WIDTH-1:0] w_index;
    logic [INDEX_WIDTH-1:0] r_ptr;
    logic [INDEX_WIDTH-1:0] w_ptr;

    logic [INDEX_WIDTH-1:0] w_hi;
    logic                   w_hi_found;
    logic [INDEX_WIDTH-1:0] w_lo;
    logic [INDEX_WIDTH-1:0] w_win;
    logic                   w_owner_free;

`ifdef ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN
    logic [15:0]            r_hold;
    logic [15:0]            w_hold;
    logic                   r_timeout;
    logic                   w_timeout;
`endif

    // Winner search: lowest request above the pointer, else lowest overall.
    always_comb begin
        w_hi       = '0;
        w_hi_found = 1'b0;
        w_lo       = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (i_request[i]) begin
                if (i > int'(r_ptr)) begin
                    w_hi       = INDEX_WIDTH'(i);
                    w_hi_found = 1'b1;
                end else begin
                    w_lo = INDEX_WIDTH'(i);
                end
            end
        end
        w_win = w_hi_found ? w_hi : w_lo;
    end

    // Only the owner's release bit counts; r_grant is its one-hot mask.
    assign w_owner_free = |(i_free & r_grant);

    // Next-state and next-output logic for the IDLE/LOCKED FSM.
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_valid = r_valid;
        w_index = r_index;
        w_ptr   = r_ptr;
`ifdef ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN
        w_hold    = r_hold;
        w_timeout = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (|i_request) begin
                    w_state = S_LOCKED;
                    w_grant = REQUESTERS'(1) << w_win;
                    w_valid = 1'b1;
                    w_index = w_win;
                    w_ptr   = w_win;
`ifdef ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN
                    w_hold  = '0;
`endif
                end
            end
            S_LOCKED: begin
                if (w_owner_free) begin
                    w_state = S_IDLE;
                    w_grant = '0;
                    w_valid = 1'b0;
`ifdef ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN
                end else if (r_hold == 16'(HOLD_LIMIT - 1)) begin
                    // This is the HOLD_LIMIT-th locked cycle: evict.
                    w_state   = S_IDLE;
                    w_grant   = '0;
                    w_valid   = 1'b0;
                    w_timeout = 1'b1;
                end else begin
                    w_hold = r_hold + 16'd1;
`endif
                end
            end
            default: begin
                w_state = S_IDLE;
                w_grant = '0;
                w_valid = 1'b0;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_index <= '0;
            r_ptr   <= INDEX_WIDTH'(REQUESTERS - 1);
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_valid <= w_valid;
            r_index <= w_index;
            r_ptr   <= w_ptr;
        end
    end

`ifdef ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN
    // Hold counter and one-cycle forced-release pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= w_hold;
            r_timeout <= w_timeout;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_grant       = r_grant;
    assign o_grant_valid = r_valid;
    assign o_grant_index = r_index;

endmodule

// File: tb/tb_roundrobin_arbiter_lock.sv
// Directed bench for roundrobin_arbiter_lock with a cycle-level reference model.
// Hold-limit scenario runs when ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN is defined.
module tb_roundrobin_arbiter_lock;

    localparam int N     = 4;
    localparam int LIMIT = 4;
`ifdef ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] free;
    logic [N-1:0] grant;
    logic         gvalid;
    logic [1:0]   gindex;
    logic         tmo;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = N - 1;
    int m_held  = 0;
    bit m_to    = 1'b0;

    roundrobin_arbiter_lock #(
        .REQUESTERS(N),
        .HOLD_LIMIT(LIMIT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_request    (req),
        .i_free       (free),
        .o_grant      (grant),
        .o_grant_valid(gvalid),
        .o_grant_index(gindex),
        .o_timeout    (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp,
                     $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        m_to = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 0;
            m_ptr   = N - 1;
            m_held  = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_ptr   = c;
                    m_held  = 1;
                end
            end
        end else if (free[m_owner]) begin
            m_owner = -1;
        end else if (HOLD_EN && m_held == LIMIT) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    // One cycle: update model, clock, then compare every output.
    task automatic tick();
        logic [N-1:0] eg;
        model_step();
        @(posedge clk);
        #1;
        eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
        check("grant", 32'(grant), 32'(eg));
        check("grant_valid", 32'(gvalid), 32'(m_owner >= 0));
        check("grant_index", 32'(gindex), 32'(m_last));
        check("timeout", 32'(tmo), 32'(m_to));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        free  = 4'b0000;
        #2;

        // reset with all requests pending
        repeat (3) tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(gvalid), 32'h0);
        check("rst_index", 32'(gindex), 32'h0);
        rst_n = 1'b1;
        tick();
        check("first_grant", 32'(grant), 32'h1);
        free = 4'b0001;
        tick();
        free = 4'b0000;
        req  = 4'b0000;
        tick();

        // single requester, held after request drops
        req = 4'b0100;
        tick();
        check("single_grant", 32'(grant), 32'h4);
        check("single_index", 32'(gindex), 32'h2);
        req = 4'b0000;
        repeat (3) tick();
        check("single_hold", 32'(grant), 32'h4);
        free = 4'b0100;
        tick();
        check("single_release", 32'(grant), 32'h0);
        free = 4'b0000;
        tick();

        // rotation from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rot_grant", 32'(grant), 32'(1 << (g % N)));
            tick();
            free = 4'(1 << (g % N));
            tick();
            check("rot_bubble", 32'(grant), 32'h0);
            free = 4'b0000;
        end
        req = 4'b0000;
        tick();

        // non-owner release is ignored
        req = 4'b0010;
        tick();
        check("nonown_grant", 32'(grant), 32'h2);
        req  = 4'b0000;
        free = 4'b1101;
        repeat (2) tick();
        check("nonown_hold", 32'(grant), 32'h2);
        free = 4'b0010;
        tick();
        check("nonown_release", 32'(grant), 32'h0);
        free = 4'b0000;

        // wrap and skip from pointer 3
        req = 4'b1000;
        tick();
        check("wrap_own3", 32'(gindex), 32'h3);
        free = 4'b1000;
        tick();
        free = 4'b0000;
        req  = 4'b1010;
        tick();
        check("wrap_grant1", 32'(grant), 32'h2);
        check("wrap_index1", 32'(gindex), 32'h1);
        free = 4'b0010;
        tick();
        free = 4'b0000;
        tick();
        check("skip_grant3", 32'(grant), 32'h8);
        free = 4'b1000;
        req  = 4'b0000;
        tick();
        free = 4'b0000;
        tick();

        // owner requesting while releasing: release, then re-win alone
        req = 4'b0001;
        tick();
        free = 4'b0001;
        tick();
        check("simul_release", 32'(grant), 32'h0);
        free = 4'b0000;
        tick();
        check("rewin_grant", 32'(grant), 32'h1);

        // reset mid-grant drops it at once
        rst_n = 1'b0;
        tick();
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_index", 32'(gindex), 32'h0);
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();

`ifdef ROUNDROBIN_ARBITER_LOCK_HOLD_LIMIT_EN
        // forced release after LIMIT locked cycles
        req = 4'b0011;
        tick();
        check("hold_grant0", 32'(grant), 32'h1);
        repeat (LIMIT - 1) tick();
        check("hold_still", 32'(grant), 32'h1);
        tick();
        check("hold_evict", 32'(grant), 32'h0);
        check("hold_pulse", 32'(tmo), 32'h1);
        tick();
        check("hold_next1", 32'(grant), 32'h2);
        check("hold_pulse_end", 32'(tmo), 32'h0);
        free = 4'b0010;
        req  = 4'b0000;
        tick();
        free = 4'b0000;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
